// File: rtl/idct_1d_pipe.sv
// Pipelined 8-point 1-D inverse DCT, one row of coefficients per beat, global-stall flow control.
// Also tracks block framing (sticky proto_err) and a per-frame count of saturated output beats.
module idct_1d_pipe #(
  parameter int W_O = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [7:0][15:0]    in_data,
  input  logic                in_sob,
  input  logic                in_eob,
  input  logic                in_sof,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [7:0][W_O-1:0] out_data,
  output logic                out_sob,
  output logic                out_eob,
  output logic                out_sof,
  output logic [15:0]         sat_cnt,
  output logic                proto_err
);

  localparam int MAXV = (1 << (W_O - 1)) - 1;
  localparam int MINV = -(1 << (W_O - 1));
  localparam logic signed [20:0] L_MAX = 21'(MAXV);
  localparam logic signed [20:0] L_MIN = 21'(MINV);

  // 4096*cos(i*pi/16) for i = 0..8
  function automatic logic signed [14:0] cos_mag(input int i);
    case (i)
      0:       return 15'sd4096;
      1:       return 15'sd4017;
      2:       return 15'sd3784;
      3:       return 15'sd3406;
      4:       return 15'sd2896;
      5:       return 15'sd2276;
      6:       return 15'sd1567;
      7:       return 15'sd799;
      default: return 15'sd0;
    endcase
  endfunction

  // Folds the angle (2n+1)k*pi/16 back into the first quadrant.
  function automatic logic signed [14:0] coef(input int n, input int k);
    int m;
    m = ((2 * n + 1) * k) % 32;
    if (k == 0)       return 15'sd2896;
    else if (m <= 8)  return cos_mag(m);
    else if (m <= 16) return -cos_mag(16 - m);
    else if (m <= 24) return -cos_mag(m - 16);
    else              return cos_mag(32 - m);
  endfunction

  logic                    w_en;
  logic                    w_acc;
  logic                    w_xfer;
  logic [7:0]              r_vld;
  logic [7:0][2:0]         r_mk;
  logic signed [15:0]      r_x   [8];
  logic signed [30:0]      r_p2  [8][8];
  logic signed [30:0]      r_p3  [8][8];
  logic signed [31:0]      r_s4  [8][4];
  logic signed [32:0]      r_s5  [8][2];
  logic signed [33:0]      r_acc [8];
  logic signed [33:0]      w_rsum[8];
  logic signed [20:0]      r_rnd [8];
  logic [W_O-1:0]          w_sat [8];
  logic                    w_clip;
  logic [7:0][W_O-1:0]     r_out;
  logic                    r_clip;
  logic [15:0]             r_sat_cnt;
  logic                    r_in_block;
  logic [2:0]              r_cnt;
  logic                    r_perr;
  logic                    w_blk_nxt;
  logic [2:0]              w_cnt_nxt;
  logic [3:0]              w_cnt_inc;
  logic                    w_err;

  assign w_en      = ~(r_vld[7] & ~out_ready);
  assign in_ready  = w_en;
  assign w_acc     = in_valid & w_en;
  assign w_xfer    = r_vld[7] & out_ready;
  assign out_valid = r_vld[7];
  assign out_sob   = r_mk[7][2];
  assign out_eob   = r_mk[7][1];
  assign out_sof   = r_mk[7][0];
  assign out_data  = r_out;
  assign sat_cnt   = r_sat_cnt;
  assign proto_err = r_perr;

  // Datapath stages only load when their incoming beat is valid; no reset needed.
  always_ff @(posedge clk) begin
    if (w_en && in_valid)
      for (int k = 0; k < 8; k++) r_x[k] <= $signed(in_data[k]);
    if (w_en && r_vld[0])
      for (int n = 0; n < 8; n++)
        for (int k = 0; k < 8; k++) r_p2[n][k] <= 31'(r_x[k]) * 31'(coef(n, k));
    if (w_en && r_vld[1])
      for (int n = 0; n < 8; n++)
        for (int k = 0; k < 8; k++) r_p3[n][k] <= r_p2[n][k];
    if (w_en && r_vld[2])
      for (int n = 0; n < 8; n++)
        for (int j = 0; j < 4; j++) r_s4[n][j] <= 32'(r_p3[n][2*j]) + 32'(r_p3[n][2*j+1]);
    if (w_en && r_vld[3])
      for (int n = 0; n < 8; n++)
        for (int j = 0; j < 2; j++) r_s5[n][j] <= 33'(r_s4[n][2*j]) + 33'(r_s4[n][2*j+1]);
    if (w_en && r_vld[4])
      for (int n = 0; n < 8; n++) r_acc[n] <= 34'(r_s5[n][0]) + 34'(r_s5[n][1]);
    if (w_en && r_vld[5])
      for (int n = 0; n < 8; n++) r_rnd[n] <= 21'(w_rsum[n] >>> 13);
  end

  always_comb begin
    for (int n = 0; n < 8; n++) w_rsum[n] = r_acc[n] + 34'sd4096;
  end

  always_comb begin
    w_clip = 1'b0;
    for (int n = 0; n < 8; n++) begin
      if (r_rnd[n] > L_MAX) begin
        w_sat[n] = L_MAX[W_O-1:0];
        w_clip   = 1'b1;
      end else if (r_rnd[n] < L_MIN) begin
        w_sat[n] = L_MIN[W_O-1:0];
        w_clip   = 1'b1;
      end else begin
        w_sat[n] = r_rnd[n][W_O-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld  <= '0;
      r_mk   <= '0;
      r_out  <= '0;
      r_clip <= 1'b0;
    end else if (w_en) begin
      r_vld <= {r_vld[6:0], in_valid};
      r_mk  <= {r_mk[6:0], (in_valid ? {in_sob, in_eob, in_sof} : 3'b000)};
      if (r_vld[6]) begin
        for (int n = 0; n < 8; n++) r_out[n] <= w_sat[n];
        r_clip <= w_clip;
      end
    end
  end

  // A sof beat restarts the per-frame count with its own clip flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat_cnt <= '0;
    end else if (w_xfer) begin
      if (out_sof)
        r_sat_cnt <= {15'd0, r_clip};
      else if (r_sat_cnt != 16'hFFFF)
        r_sat_cnt <= r_sat_cnt + {15'd0, r_clip};
    end
  end

  always_comb begin
    w_blk_nxt = r_in_block;
    w_cnt_nxt = r_cnt;
    w_err     = 1'b0;
    w_cnt_inc = {1'b0, r_cnt} + 4'd1;
    if (w_acc) begin
      if (in_sob) begin
        w_err     = r_in_block | in_eob;
        w_blk_nxt = 1'b1;
        w_cnt_nxt = 3'd1;
      end else if (!r_in_block) begin
        w_err = 1'b1;
      end else if (w_cnt_inc == 4'd8) begin
        w_err     = ~in_eob;
        w_blk_nxt = 1'b0;
        w_cnt_nxt = 3'd0;
      end else begin
        w_err     = in_eob;
        w_cnt_nxt = w_cnt_inc[2:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_block <= 1'b0;
      r_cnt      <= '0;
      r_perr     <= 1'b0;
    end else begin
      r_in_block <= w_blk_nxt;
      r_cnt      <= w_cnt_nxt;
      r_perr     <= r_perr | w_err;
    end
  end

endmodule

// File: tb/tb_idct_1d_pipe.sv
// Directed bench for idct_1d_pipe: W_O=16 and W_O=12 instances share the same stimulus,
// outputs are checked in order against an integer model using an independently written table.
module tb_idct_1d_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic             in_valid, in_sob, in_eob, in_sof, out_ready;
  logic [7:0][15:0] in_data;
  logic             rdy16, ov16, ob16, oe16, of16, perr16;
  logic [7:0][15:0] od16;
  logic [15:0]      sat16;
  logic             rdy12, ov12, ob12, oe12, of12, perr12;
  logic [7:0][11:0] od12;
  logic [15:0]      sat12;

  idct_1d_pipe #(.W_O(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy16), .in_data(in_data),
    .in_sob(in_sob), .in_eob(in_eob), .in_sof(in_sof), .out_valid(ov16), .out_ready(out_ready),
    .out_data(od16), .out_sob(ob16), .out_eob(oe16), .out_sof(of16), .sat_cnt(sat16),
    .proto_err(perr16));

  idct_1d_pipe #(.W_O(12)) dut12 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy12), .in_data(in_data),
    .in_sob(in_sob), .in_eob(in_eob), .in_sof(in_sof), .out_valid(ov12), .out_ready(out_ready),
    .out_data(od12), .out_sob(ob12), .out_eob(oe12), .out_sof(of12), .sat_cnt(sat12),
    .proto_err(perr12));

  // CT[k][n]
  int CT[8][8] = '{
    '{2896, 2896, 2896, 2896, 2896, 2896, 2896, 2896},
    '{4017, 3406, 2276, 799, -799, -2276, -3406, -4017},
    '{3784, 1567, -1567, -3784, -3784, -1567, 1567, 3784},
    '{3406, -799, -4017, -2276, 2276, 4017, 799, -3406},
    '{2896, -2896, -2896, 2896, 2896, -2896, -2896, 2896},
    '{2276, -4017, 799, 3406, -3406, -799, 4017, -2276},
    '{1567, -3784, 3784, -1567, -1567, 3784, -3784, 1567},
    '{799, -2276, 3406, -4017, 4017, -3406, 2276, -799}
  };

  typedef struct {
    logic [7:0][15:0] d16;
    logic [7:0][11:0] d12;
    logic [2:0]       mk;
    bit               c16;
    bit               c12;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   fpos = 0;
  int   blk_len = 8;
  int   m_sat16 = 0;
  int   m_sat12 = 0;
  int   n_in = 0;
  int   n_out = 0;
  bit   lat_arm = 0;
  int   t_acc = -1;
  int   t_out = -1;
  logic [7:0][15:0] first16, last16;
  logic [7:0][11:0] last12;
  logic [2:0]       first_mk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [7:0][15:0] x, output exp_t e);
    longint acc, r;
    e.c16 = 0;
    e.c12 = 0;
    e.mk  = 3'b000;
    for (int n = 0; n < 8; n++) begin
      acc = 0;
      for (int k = 0; k < 8; k++) acc += longint'($signed(x[k])) * longint'(CT[k][n]);
      r = (acc + 4096) >>> 13;
      if (r > 32767)       begin e.d16[n] = 16'h7FFF; e.c16 = 1; end
      else if (r < -32768) begin e.d16[n] = 16'h8000; e.c16 = 1; end
      else                 e.d16[n] = 16'(r);
      if (r > 2047)        begin e.d12[n] = 12'h7FF; e.c12 = 1; end
      else if (r < -2048)  begin e.d12[n] = 12'h800; e.c12 = 1; end
      else                 e.d12[n] = 12'(r);
    end
  endtask

  function automatic logic [7:0][15:0] rand_row();
    logic [7:0][15:0]   r;
    logic signed [15:0] v;
    for (int k = 0; k < 8; k++) begin
      v = 16'($urandom);
      v = v >>> $urandom_range(0, 6);
      r[k] = v;
    end
    return r;
  endfunction

  task automatic drive(input logic [7:0][15:0] x, input bit sof_req);
    in_data  = x;
    in_valid = 1'b1;
    in_sob   = (fpos == 0);
    in_eob   = (fpos == blk_len - 1);
    in_sof   = sof_req && (fpos == 0);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_sob   = 1'b0;
    in_eob   = 1'b0;
    in_sof   = 1'b0;
  endtask

  // Checks at negedge+1, then advances one clock and returns at the next negedge.
  task automatic tick(output bit acc);
    exp_t e;
    #1;
    check("sat_cnt16", sat16, m_sat16);
    check("sat_cnt12", sat12, m_sat12);
    acc = in_valid && rdy16;
    if (ov16 && out_ready) begin
      if (q.size() == 0) begin
        check("outputs_vs_accepts", n_out + 1, n_in);
      end else begin
        e = q.pop_front();
        check("data16", od16, e.d16);
        check("data12", od12, e.d12);
        check("markers16", {ob16, oe16, of16}, e.mk);
        check("markers12", {ob12, oe12, of12}, e.mk);
        check("valid12", ov12, 1'b1);
        last16 = od16;
        last12 = od12;
        if (lat_arm) begin
          t_out    = cyc;
          first16  = od16;
          first_mk = {ob16, oe16, of16};
          lat_arm  = 0;
        end
        if (e.mk[0]) begin
          m_sat16 = e.c16;
          m_sat12 = e.c12;
        end else begin
          if (m_sat16 != 65535) m_sat16 += e.c16;
          if (m_sat12 != 65535) m_sat12 += e.c12;
        end
      end
      n_out++;
    end
    if (acc) begin
      model(in_data, e);
      e.mk = {in_sob, in_eob, in_sof};
      q.push_back(e);
      n_in++;
      fpos = (fpos + 1) % blk_len;
      if (lat_arm && t_acc < 0) t_acc = cyc;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0][15:0] x, input bit sof_req);
    bit a;
    int g;
    drive(x, sof_req);
    g = 0;
    do begin
      tick(a);
      g++;
    end while (!a && g < 50);
    check("accept", a, 1'b1);
  endtask

  task automatic drain();
    bit a;
    int g;
    idle();
    out_ready = 1'b1;
    g = 0;
    while (q.size() > 0 && g < 100) begin
      tick(a);
      g++;
    end
    check("drain_left", q.size(), 0);
  endtask

  task automatic check_reset_state();
    #1;
    check("rst_valid16", ov16, 1'b0);
    check("rst_valid12", ov12, 1'b0);
    check("rst_markers", {ob16, oe16, of16, ob12, oe12, of12}, 6'b0);
    check("rst_data16", od16, 128'd0);
    check("rst_data12", od12, 96'd0);
    check("rst_sat16", sat16, 16'd0);
    check("rst_sat12", sat12, 16'd0);
    check("rst_perr", {perr16, perr12}, 2'b00);
    check("rst_ready", {rdy16, rdy12}, 2'b11);
  endtask

  initial begin
    bit a;
    int na;
    int g;
    bit pend;
    logic [7:0][15:0] row;

    rst_n = 1'b1;
    idle();
    in_data   = '0;
    out_ready = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_reset_state();
    @(negedge clk);

    // DC block: latency, value and marker alignment
    row = '0;
    row[0] = 16'd8192;
    lat_arm = 1;
    for (int i = 0; i < 8; i++) send(row, i == 0);
    drain();
    check("latency", t_out - t_acc, 8);
    check("dc_value", first16, {8{16'd2896}});
    check("dc_first_markers", first_mk, 3'b101);

    // Saturation: every beat clips at 12 bits, none at 16
    for (int i = 0; i < 8; i++) begin
      row = '0;
      row[0] = (i % 2 == 0) ? 16'h7FFF : 16'h8000;
      send(row, i == 0);
    end
    drain();
    check("sat_neg12", last12, {8{12'h800}});
    check("sat_neg16", last16, {8{16'hD2C0}});
    check("sat_cnt12_block", sat12, 16'd8);
    check("sat_cnt16_block", sat16, 16'd0);
    row = '0;
    row[0] = 16'h7FFF;
    send(row, 1'b1);
    drain();
    check("sat_pos12", last12, {8{12'h7FF}});
    check("sat_cnt12_sof_clip", sat12, 16'd1);
    row = '0;
    for (int i = 0; i < 7; i++) send(row, 1'b0);
    drain();
    check("sat_cnt12_after", sat12, 16'd1);
    for (int i = 0; i < 8; i++) send(row, i == 0);
    drain();
    check("sat_cnt12_reload", sat12, 16'd0);
    check("perr_good_blocks", {perr16, perr12}, 2'b00);

    // Back-pressure: 16 beats, out_ready low for 5 cycles mid-stream
    pend = 0;
    na   = 0;
    for (int t = 0; t < 80 && na < 16; t++) begin
      out_ready = !(t >= 8 && t < 13);
      if (!pend) begin
        drive(rand_row(), na == 0);
        pend = 1;
      end
      if (t >= 8 && t < 13) begin
        #1;
        check("bp_ready16", rdy16, 1'b0);
        check("bp_ready12", rdy12, 1'b0);
      end
      tick(a);
      if (a) begin
        na++;
        pend = 0;
      end
    end
    check("bp_beats", na, 16);
    drain();

    // Random traffic with random valid/ready
    pend = 0;
    na   = 0;
    g    = 0;
    while (na < 1000 && g < 6000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!pend) begin
        if ($urandom_range(0, 3) != 0) begin
          drive(rand_row(), $urandom_range(0, 3) == 0);
          pend = 1;
        end else begin
          idle();
        end
      end
      tick(a);
      if (a) begin
        na++;
        pend = 0;
      end
      g++;
    end
    check("random_beats", na, 1000);
    drain();
    check("beat_count", n_out, n_in);
    check("perr_after_random", {perr16, perr12}, 2'b00);

    // Framing: eob on beat 7 is an error that stays set
    blk_len = 7;
    for (int i = 0; i < 7; i++) send(rand_row(), i == 0);
    blk_len = 8;
    drain();
    check("perr_short_block", {perr16, perr12}, 2'b11);
    for (int i = 0; i < 8; i++) send(rand_row(), i == 0);
    drain();
    check("perr_sticky", {perr16, perr12}, 2'b11);

    // Reset with four beats in flight
    for (int i = 0; i < 4; i++) send(rand_row(), i == 0);
    idle();
    rst_n = 1'b0;
    q.delete();
    m_sat16 = 0;
    m_sat12 = 0;
    fpos    = 0;
    n_in    = 0;
    n_out   = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_reset_state();
    for (int i = 0; i < 12; i++) begin
      tick(a);
      check("post_rst_valid", {ov16, ov12}, 2'b00);
    end
    check("post_rst_perr", {perr16, perr12}, 2'b00);
    for (int i = 0; i < 8; i++) send(rand_row(), i == 0);
    drain();
    check("post_rst_count", n_out, 8);
    check("post_rst_perr_block", {perr16, perr12}, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
